// File: rtl/multdiv_issue_ctrl_if.sv
// rtl/multdiv_issue_ctrl_if.sv - issue, multdiv and writeback signals of the multdiv sequencer
interface multdiv_issue_ctrl_if #(
  parameter int RD_W = 5
);
  logic            issue_valid;
  logic            issue_ready;
  logic            issue_is_div;
  logic [31:0]     issue_opA;
  logic [31:0]     issue_opB;
  logic [RD_W-1:0] issue_rd;
  logic            busy;
  logic            flush;
  logic [31:0]     md_operandA;
  logic [31:0]     md_operandB;
  logic            md_ctrl_MULT;
  logic            md_ctrl_DIV;
  logic [31:0]     md_result;
  logic            md_exception;
  logic            md_resultRDY;
  logic            md_running;
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_exception;

  // Sequencer side
  modport slave (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
           md_result, md_exception, md_resultRDY, md_running, wb_ready,
    output issue_ready, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception
  );

  // Pipeline / multdiv / writeback side
  modport master (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
           md_result, md_exception, md_resultRDY, md_running, wb_ready,
    input  issue_ready, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - one-at-a-time MUL/DIV issue sequencer with flush, timeout and x0 discard
module multdiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RD_W           = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multdiv_issue_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, DRAIN} state_t;

  state_t          state;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            is_div;
  logic [RD_W-1:0] rd;
  logic [CW-1:0]   cnt;
  logic [31:0]     wb_data_q;
  logic            wb_exc_q;

  logic [CW-1:0]   cnt_inc;
  logic            timeout;

  // Timeout fires on the cycle the saturating counter would reach its last value
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign timeout = (cnt_inc >= CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      is_div    <= 1'b0;
      rd        <= '0;
      cnt       <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid && !bus.flush) begin
            op_a   <= bus.issue_opA;
            op_b   <= bus.issue_opB;
            is_div <= bus.issue_is_div;
            rd     <= bus.issue_rd;
            state  <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= bus.flush ? DRAIN : BUSY;
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (bus.flush) begin
            state <= DRAIN;
          end else if (bus.md_resultRDY) begin
            wb_data_q <= bus.md_result;
            wb_exc_q  <= bus.md_exception;
            // Results for x0 are dropped without a writeback cycle
            state     <= (rd != '0) ? DONE : IDLE;
          end else if (timeout) begin
            wb_data_q <= '0;
            wb_exc_q  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.flush || bus.wb_ready) state <= IDLE;
        end
        DRAIN: begin
          cnt <= cnt_inc;
          if (bus.md_resultRDY || !bus.md_running || timeout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready  = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.md_operandA  = op_a;
  assign bus.md_operandB  = op_b;
  assign bus.md_ctrl_MULT = (state == START) && !is_div;
  assign bus.md_ctrl_DIV  = (state == START) && is_div;
  assign bus.wb_valid     = (state == DONE);
  assign bus.wb_rd        = rd;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;
endmodule
